// File: rtl/alu_rf_pipe_pkg.sv
// Shared encodings for the pipelined register-file + ALU datapath.
package alu_rf_pipe_pkg;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_OR  = 4'b0001;
  localparam logic [3:0] FN_ADD = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b0110;
  localparam logic [3:0] FN_SLT = 4'b0111;
  localparam logic [3:0] FN_NOR = 4'b1100;
  localparam logic [3:0] FN_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/alu_rf_pipe_regfile.sv
// Register file: two combinational read ports, ALU and external write ports
// (ALU wins on an address clash), optional hard-wired zero register.
module alu_rf_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] read_addr1,
  input  logic [$clog2(NUM_REGS)-1:0] read_addr2,
  output logic [DATA_W-1:0]           read_data1,
  output logic [DATA_W-1:0]           read_data2,
  input  logic                        alu_we,
  input  logic [$clog2(NUM_REGS)-1:0] alu_addr,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        ext_we,
  input  logic [$clog2(NUM_REGS)-1:0] ext_addr,
  input  logic [DATA_W-1:0]           ext_data
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign read_data1 = (ZERO_REG != 0 && read_addr1 == '0) ? '0 : regs[read_addr1];
  assign read_data2 = (ZERO_REG != 0 && read_addr2 == '0) ? '0 : regs[read_addr2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          if (alu_we && alu_addr == AW'(i))      regs[i] <= alu_data;
          else if (ext_we && ext_addr == AW'(i)) regs[i] <= ext_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_rf_pipe.sv
// Register file + ALU with registered result, writeback bypass and an
// iterative shift-add multiplier that stalls the input handshake.
module alu_rf_pipe
  import alu_rf_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(NUM_REGS)-1:0] read1,
  input  logic [$clog2(NUM_REGS)-1:0] read2,
  input  logic [$clog2(NUM_REGS)-1:0] write_reg,
  input  logic                        reg_write,
  input  logic [1:0]                  alu_op,
  input  logic [3:0]                  func_code,
  input  logic                        ext_we,
  input  logic [$clog2(NUM_REGS)-1:0] ext_waddr,
  input  logic [DATA_W-1:0]           ext_wdata,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           alu_out,
  output logic                        zero,
  output logic                        overflow,
  output logic                        illegal,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(DATA_W + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_next_c;
  logic              wb_en;
  logic [AW-1:0]     wb_reg;
  logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b;
  logic [DATA_W-1:0] res_c, sum_c, diff_c;
  logic              ovf_c, ill_c, mul_c, accept_c;

  alu_rf_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .read_addr1(read1),
    .read_addr2(read2),
    .read_data1(rf_a),
    .read_data2(rf_b),
    .alu_we    (out_valid && wb_en),
    .alu_addr  (wb_reg),
    .alu_data  (alu_out),
    .ext_we    (ext_we),
    .ext_addr  (ext_waddr),
    .ext_data  (ext_wdata)
  );

  // Forward the result still waiting to be written back.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (out_valid && wb_en && wb_reg == read1 && !(ZERO_REG != 0 && read1 == '0)) op_a = alu_out;
    if (out_valid && wb_en && wb_reg == read2 && !(ZERO_REG != 0 && read2 == '0)) op_b = alu_out;
  end

  assign accept_c   = in_valid && in_ready;
  assign acc_next_c = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    res_c  = '0;
    ovf_c  = 1'b0;
    ill_c  = 1'b0;
    mul_c  = 1'b0;
    sum_c  = op_a + op_b;
    diff_c = op_a - op_b;
    case (alu_op)
      ALUOP_ADD: begin
        res_c = sum_c;
        ovf_c = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_c[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALUOP_SUB: begin
        res_c = diff_c;
        ovf_c = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff_c[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALUOP_FUNC: begin
        case (func_code)
          FN_AND: res_c = op_a & op_b;
          FN_OR:  res_c = op_a | op_b;
          FN_NOR: res_c = ~(op_a | op_b);
          FN_SLT: res_c = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
          FN_MUL: mul_c = 1'b1;
          FN_ADD: begin
            res_c = sum_c;
            ovf_c = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_c[DATA_W-1] != op_a[DATA_W-1]);
          end
          FN_SUB: begin
            res_c = diff_c;
            ovf_c = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff_c[DATA_W-1] != op_a[DATA_W-1]);
          end
          default: ill_c = 1'b1;
        endcase
      end
      default: ill_c = 1'b1;
    endcase
  end

  // Control FSM; DONE accepts like IDLE so the input is not stalled after a multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      wb_en     <= 1'b0;
      wb_reg    <= '0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        MUL: begin
          acc    <= acc_next_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            alu_out   <= acc_next_c;
            zero      <= (acc_next_c == '0);
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          overflow  <= 1'b0;
          illegal   <= 1'b0;
          if (accept_c) begin
            wb_reg <= write_reg;
            wb_en  <= reg_write && !ill_c;
            if (mul_c) begin
              state    <= MUL;
              cnt      <= CW'(DATA_W);
              mcand    <= op_a;
              mplier   <= op_b;
              acc      <= '0;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              alu_out   <= res_c;
              zero      <= (res_c == '0);
              overflow  <= ovf_c;
              illegal   <= ill_c;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_rf_pipe.md
Name: alu_rf_pipe

Overview:
- Parametrised successor to the combinational register-file-plus-ALU datapath.
- Holds an N-entry register file, accepts one instruction per cycle through a valid/ready handshake, and registers the ALU result.
- Writes the result back to the register file, with bypass so back-to-back dependent instructions need no stall.
- Adds an iterative multi-cycle multiply with a busy/stall state machine, plus an external write port used for loads and initialisation.

Parameters:
- DATA_W, 32, operand/result width (>=8).
- NUM_REGS, 32, register count; address width AW = clog2(NUM_REGS).
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept an instruction this cycle
- read1  in  AW  source register A
- read2  in  AW  source register B
- write_reg  in  AW  destination register
- reg_write  in  1  write the result back to write_reg
- alu_op  in  2  00 ADD, 01 SUB, 10 use func_code, 11 illegal
- func_code  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MUL; others illegal
- ext_we  in  1  external register write enable
- ext_waddr  in  AW  external write address
- ext_wdata  in  DATA_W  external write data
- out_valid  out  1  one-cycle pulse: result valid
- alu_out  out  DATA_W  registered result
- zero  out  1  alu_out == 0, registered with the result
- overflow  out  1  signed overflow on ADD/SUB; 0 for other ops
- illegal  out  1  pulses with out_valid for an undefined op
- busy  out  1  multiply in progress

Behaviour:
- Reset (synchronous) sets:
  - every register to 0
  - out_valid, alu_out, zero, overflow, illegal and busy to 0
  - in_ready to 1
  - FSM to IDLE
- Reset mid-multiply aborts the multiply with no output pulse and no writeback.
- Accept: an instruction is accepted on an edge where in_valid && in_ready.
- Operand read:
  - Combinational from the RF in the accept cycle.
  - Bypass: if out_valid && the pending writeback is enabled && its register == readX (and it is not register 0 when ZERO_REG), the operand is alu_out.
  - An ext_we to readX in the same cycle is not bypassed (normal RF timing).
- Single-cycle ops:
  - Result is registered on the accept edge; out_valid is high the next cycle (latency 1).
  - Full throughput: in_ready stays 1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W.
  - overflow = signed overflow of that ADD/SUB.
  - SLT yields 1 or 0 (signed compare).
  - MUL yields the low DATA_W bits of the unsigned product.
- Illegal op (alu_op=11 or undefined func_code): alu_out = 0, zero = 1, illegal = 1, no writeback.
- FSM:
  - IDLE: accepting MUL goes to MUL, loads the operands and sets counter = DATA_W; busy = 1 and in_ready = 0 from the next cycle.
  - MUL: one shift-add step per cycle; the counter decrements; when it reaches 0, go to DONE.
  - DONE: out_valid pulses with the product, writeback occurs, busy drops, in_ready = 1, return to IDLE.
  - A MUL accepted at edge T gives out_valid in cycle T+DATA_W+1.
- Writeback:
  - On the edge ending an out_valid cycle, if the latched reg_write is set and the op was legal, RF[write_reg] <= alu_out.
  - Writes to register 0 are dropped when ZERO_REG.
- Write-port conflict: the ALU writeback and ext_we may occur in the same cycle. If both target the same register, the ALU writeback wins; otherwise both are performed.
- No output backpressure: the consumer must take out_valid when it pulses.

Decomposition:
- Shared package holds:
  - alu_op encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC
  - func_code constants: FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_NOR, FN_MUL
  - FSM state enum: IDLE, MUL, DONE
- One sub-module is natural: alu_rf_regfile, holding the parametrised array with two combinational read ports, two write ports with the ALU-priority rule, and the zero-register handling.
- The ALU and FSM stay in the top module.

Test Plan:
- Reset, then ext_we writes R1=5 and R2=3; then ADD 1,2→R3 -> the next cycle gives out_valid=1, alu_out=8, zero=0; R3 then reads 8.
- Back-to-back dependency: SUB 1,2→R4, then next cycle ADD 4,4→R5 -> alu_out=2 and then 4 (bypass used; no stall, in_ready stays 1).
- Edge arithmetic: R1=0x7FFFFFFF, R2=1, ADD -> alu_out=0x80000000, overflow=1; SUB of equal operands -> alu_out=0, zero=1; SLT with -1 vs 1 -> 1.
- MUL R1=6, R2=7 -> busy and in_ready=0 for 32 cycles, out_valid in cycle T+33 with alu_out=42; an instruction held at in_valid during this time is accepted only after DONE.
- Write R0 via ALU and via ext_we with ZERO_REG=1 -> R0 reads 0. Same-cycle ALU writeback and ext_we both targeting R6 -> R6 holds the ALU value.
- Illegal alu_op=11 -> illegal=1, alu_out=0, no writeback. Reset asserted mid-MUL -> busy=0, in_ready=1, no out_valid pulse.
